delay_meter: RTL
================

Name: delay_meter

Overview:
- Measures the clock-cycle distance between a rising edge on start_in and a subsequent rising edge on stop_in.
- Acts as the reading end of the loadable-counter delay path. The counter generates a programmed delay; this block measures it and returns the count over an 8-bit byte-selected bus.
- Sits behind the top-level pin wrapper: start_in/stop_in come from dedicated inputs, and the result goes to dedicated outputs.

Parameters:
- WIDTH, 16, measurement counter/result width; legal range 9..16. Upper read byte is zero-extended when WIDTH < 16.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; when low, state and counter freeze
- arm  input  1  synchronous pulse; (re)arms a measurement
- start_in  input  1  asynchronous start strobe
- stop_in  input  1  asynchronous stop strobe
- rd_hi  input  1  byte select for result_o: 0 = bits [7:0], 1 = bits [WIDTH-1:8]
- result_o  output  8  selected byte of captured result
- valid  output  1  high while result holds a completed measurement
- busy  output  1  high in ARMED or COUNTING
- overflow  output  1  counter saturated during the last/current measurement

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt=0; result=0; valid=0; busy=0; overflow=0.
  - Synchronizer and edge-history flops cleared to 0.
  - Reset mid-measurement aborts immediately; no partial result.
- Input conditioning:
  - start_in and stop_in each pass through a SYNC_STAGES flop chain, then one edge-history flop.
  - edge = synced & ~history.
  - Both paths have identical latency, so latency cancels in the measured value.
  - Synchronizers and history flops run regardless of ena. Edges detected while ena=0 are discarded.
- State machine (advances only when ena=1):
  - IDLE: arm -> ARMED; clear valid, overflow, cnt.
  - ARMED: start_edge -> COUNTING, cnt<=1. stop_edge is ignored. A start and stop edge in the same cycle: start taken, stop ignored.
  - COUNTING, each cycle:
    - If stop_edge: result<=cnt, valid<=1, -> DONE.
    - Else if cnt == 2^WIDTH-1: hold cnt, overflow<=1.
    - Else cnt<=cnt+1.
    - Further start edges are ignored.
  - DONE: result and valid hold. arm -> ARMED; clears valid and overflow; result register keeps its old value until the next capture.
  - arm in ARMED or COUNTING: abort and restart in ARMED; cnt<=0, overflow<=0.
  - arm has priority over start_edge/stop_edge in the same cycle.
- Measured value:
  - result = N, where the stop edge is detected N clocks after the start edge is detected. Equivalently, stop_in rising N clocks after start_in rising, with both stable across sampling.
  - Minimum measurable value is 1; equal-cycle edges are never measured.
  - On saturation, result = 2^WIDTH-1 with overflow=1.
- Outputs:
  - busy = (state==ARMED || state==COUNTING), registered with state.
  - valid and overflow are registered.
  - result_o is a combinational mux of the result register by rd_hi, with no extra latency.
  - result_o shows the last captured result even when valid=0.
- ena=0: all registers except the synchronizer/history flops hold; outputs remain stable.

Test Plan:
- Reset, then arm; start_in rises at cycle 10, stop_in rises at cycle 15 (held high) -> valid=1, result=5: rd_hi=0 gives 0x05, rd_hi=1 gives 0x00; busy=0; overflow=0.
- Arm; start at cycle 0, stop at cycle 300 -> result=300: low byte 0x2C, high byte 0x01; arm again -> valid=0, result_o still 0x2C/0x01 until the next capture.
- WIDTH=9; arm; start, then no stop for 600 cycles; then stop -> overflow=1, result=511: low 0xFF, high 0x01.
- Arm; start and stop rise on the same clock -> remains COUNTING, valid=0. Later stop toggles low, then high 7 cycles after start -> result=7.
- Arm; start; pull rst_n low 4 cycles into COUNTING -> all outputs 0 immediately, state IDLE. A subsequent stop edge produces no capture.
- Arm; start; drop ena for 3 cycles mid-count; stop 10 cycles after start -> result=7. A stop edge occurring wholly while ena=0 is missed and valid stays 0.

Source files
------------

// File: rtl/delay_meter.sv
// Start-to-stop interval meter: measures the clock distance between two asynchronous
// rising edges and returns the count over an 8-bit byte-selected bus.
module delay_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       arm,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       rd_hi,
  output logic [7:0] result_o,
  output logic       valid,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COUNTING,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t                   state;
  logic [WIDTH-1:0]         cnt;
  logic [WIDTH-1:0]         result;
  logic [SYNC_STAGES-1:0]   start_sync;
  logic [SYNC_STAGES-1:0]   stop_sync;
  logic                     start_hist;
  logic                     stop_hist;
  logic                     start_edge;
  logic                     stop_edge;
  logic [15:0]              result_ext;

  // Saturating increment: the counter parks at its maximum instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + WIDTH'(1);
  endfunction

  // Both inputs share the same chain depth so their latency cancels in the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      stop_sync  <= '0;
      start_hist <= 1'b0;
      stop_hist  <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start_in};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop_in};
      start_hist <= start_sync[SYNC_STAGES-1];
      stop_hist  <= stop_sync[SYNC_STAGES-1];
    end
  end

  assign start_edge = start_sync[SYNC_STAGES-1] & ~start_hist;
  assign stop_edge  = stop_sync[SYNC_STAGES-1] & ~stop_hist;

  // arm outranks any edge and restarts from ARMED whatever the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else if (ena) begin
      if (arm) begin
        state    <= S_ARMED;
        cnt      <= '0;
        valid    <= 1'b0;
        busy     <= 1'b1;
        overflow <= 1'b0;
      end else begin
        case (state)
          S_ARMED: begin
            if (start_edge) begin
              state <= S_COUNTING;
              cnt   <= WIDTH'(1);
            end
          end
          S_COUNTING: begin
            if (stop_edge) begin
              result <= cnt;
              valid  <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else begin
              cnt      <= sat_inc(cnt);
              overflow <= overflow | (cnt == CNT_MAX);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign result_ext = 16'(result);
  assign result_o   = rd_hi ? result_ext[15:8] : result_ext[7:0];

endmodule
